counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 101 ++++++++++
 tb/tb_counter_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: free-running tick divider plus an up/down run sequencer driven by debounced go/pause buttons.
module counter_sequencer #(
  parameter int COUNT_WIDTH = 24,
  parameter logic [COUNT_WIDTH:0] MAX_COUNT = (COUNT_WIDTH+1)'(6000000 - 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_btn,
  input  logic       pause_btn,
  input  logic       done_up,
  input  logic       done_down,
  output logic       div_clk,
  output logic       go_up,
  output logic       go_down,
  output logic       pause_up,
  output logic       pause_down,
  output logic [2:0] state,
  output logic       busy,
  output logic [7:0] cycles
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN_UP     = 3'd1,
    PAUSE_UP   = 3'd2,
    RUN_DOWN   = 3'd3,
    PAUSE_DOWN = 3'd4
  } state_t;
  state_t               state_q, state_d;
  logic [COUNT_WIDTH:0] cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic [2:0]           go_q, go_d, pause_q, pause_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [7:0]           cycles_q, cycles_d;
  logic                 go_ev, pause_ev;
  // Per button: bit0/bit1 synchronize, bit2 holds last synchronized value for edge detection.
  assign go_ev    = go_q[1] & ~go_q[2];
  assign pause_ev = pause_q[1] & ~pause_q[2];
  always_comb begin
    cnt_d    = (cnt_q == MAX_COUNT) ? '0 : cnt_q + 1'b1;
    div_d    = cnt_q == MAX_COUNT;
    go_d     = {go_q[1:0], go_btn};
    pause_d  = {pause_q[1:0], pause_btn};
    state_d  = state_q;
    cmd_d    = '0;
    cycles_d = cycles_q;
    // cmd_d bit order: go_up, go_down, pause_up, pause_down
    case (state_q)
      IDLE: if (go_ev) begin
        state_d = RUN_UP;
        cmd_d   = 4'b1000;
      end
      RUN_UP: if (done_up) begin
        state_d = RUN_DOWN;
        cmd_d   = 4'b0100;
      end else if (pause_ev) begin
        state_d = PAUSE_UP;
        cmd_d   = 4'b0010;
      end
      PAUSE_UP: if (go_ev) begin
        state_d = RUN_UP;
        cmd_d   = 4'b1000;
      end
      RUN_DOWN: if (done_down) begin
        state_d  = IDLE;
        cycles_d = cycles_q + 8'd1;
      end else if (pause_ev) begin
        state_d = PAUSE_DOWN;
        cmd_d   = 4'b0001;
      end
      PAUSE_DOWN: if (go_ev) begin
        state_d = RUN_DOWN;
        cmd_d   = 4'b0100;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      go_q     <= '0;
      pause_q  <= '0;
      cmd_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      go_q     <= go_d;
      pause_q  <= pause_d;
      cmd_q    <= cmd_d;
      cycles_q <= cycles_d;
    end
  end
  assign div_clk = div_q;
  assign {go_up, go_down, pause_up, pause_down} = cmd_q;
  assign state  = state_q;
  assign busy   = state_q != IDLE;
  assign cycles = cycles_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: scoreboard bench; expected command pulses are queued with their due cycle when stimulus is driven.
module tb_counter_sequencer;
  logic       clk = 0, rst = 1, go_btn = 0, pause_btn = 0, done_up = 0, done_down = 0;
  logic       div_clk, go_up, go_down, pause_up, pause_down, busy;
  logic [2:0] state;
  logic [7:0] cycles;
  logic [7:0] exp_cycles = 0;
  localparam logic [3:0] GU = 4'b1000, GD = 4'b0100, PU = 4'b0010, PD = 4'b0001, NONE = 4'b0000;
  typedef struct {logic [3:0] cmd; logic [2:0] st; int due;} sb_t;
  sb_t sb[$];
  sb_t e;
  int cyc = 0, k = 0, n_cmp = 0, n_bad = 0;
  logic [3:0] cmds;

  counter_sequencer #(.COUNT_WIDTH(4), .MAX_COUNT(5'd3)) dut (
    .clk(clk), .rst(rst), .go_btn(go_btn), .pause_btn(pause_btn),
    .done_up(done_up), .done_down(done_down), .div_clk(div_clk),
    .go_up(go_up), .go_down(go_down), .pause_up(pause_up), .pause_down(pause_down),
    .state(state), .busy(busy), .cycles(cycles)
  );

  always #5 clk = ~clk;
  assign cmds = {go_up, go_down, pause_up, pause_down};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // k counts edges since the last reset edge; the divider ticks every 4th one.
  always @(posedge clk) begin
    cyc++;
    k = rst ? 0 : k + 1;
  end

  always @(negedge clk) begin
    chk("div_clk", div_clk, (k > 0 && k % 4 == 0));
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      chk("missing_cmd", NONE, e.cmd);
    end
    if (cmds != 0) begin
      if (sb.size() == 0) chk("spurious_cmd", cmds, NONE);
      else begin
        e = sb.pop_front();
        chk("cmd", cmds, e.cmd);
        chk("cmd_state", state, e.st);
        chk("cmd_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input logic [3:0] cmd, input logic [2:0] st, input int lat);
    if (cmd != 0) sb.push_back('{cmd, st, cyc + lat});
  endtask

  task automatic press(input bit pause, input logic [3:0] cmd, input logic [2:0] st);
    expect_cmd(cmd, st, 3);
    if (pause) pause_btn = 1; else go_btn = 1;
    repeat (4) tick;
    go_btn = 0;
    pause_btn = 0;
    repeat (3) tick;
    chk("state", state, st);
    chk("busy", busy, st != 0);
  endtask

  task automatic done(input bit down, input logic [3:0] cmd, input logic [2:0] st, input bit inc);
    expect_cmd(cmd, st, 1);
    if (down) done_down = 1; else done_up = 1;
    tick;
    done_up = 0;
    done_down = 0;
    repeat (2) tick;
    if (inc) exp_cycles++;
    chk("state", state, st);
    chk("cycles", cycles, exp_cycles);
  endtask

  task automatic run_full;
    press(0, GU, 1);
    done(0, GD, 3, 0);
    done(1, NONE, 0, 1);
  endtask

  task automatic chk_cleared;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_cmds", cmds, NONE);
    chk("rst_div", div_clk, 0);
  endtask

  initial begin
    repeat (2) tick;
    chk_cleared;
    rst = 0;
    repeat (13) tick;
    press(0, GU, 1);
    press(0, NONE, 1);
    done(1, NONE, 1, 0);
    done(0, GD, 3, 0);
    done(1, NONE, 0, 1);
    press(0, GU, 1);
    press(1, PU, 2);
    press(1, NONE, 2);
    done(0, NONE, 2, 0);
    press(0, GU, 1);
    done(0, GD, 3, 0);
    press(1, PD, 4);
    press(1, NONE, 4);
    done(1, NONE, 4, 0);
    press(0, GD, 3);
    done(1, NONE, 0, 1);
    // pause event and done_up land on the same edge: done wins
    press(0, GU, 1);
    pause_btn = 1;
    repeat (2) tick;
    expect_cmd(GD, 3, 1);
    done_up = 1;
    tick;
    done_up = 0;
    repeat (3) tick;
    pause_btn = 0;
    repeat (3) tick;
    chk("pause_done_state", state, 3);
    done(1, NONE, 0, 1);
    // go and pause together in IDLE: only the go action
    expect_cmd(GU, 1, 3);
    go_btn = 1;
    pause_btn = 1;
    repeat (4) tick;
    go_btn = 0;
    pause_btn = 0;
    repeat (3) tick;
    chk("go_pause_state", state, 1);
    done(0, GD, 3, 0);
    done(1, NONE, 0, 1);
    while (exp_cycles != 8'd255) run_full;
    run_full;
    chk("cycles_wrap", cycles, 0);
    run_full;
    // reset while paused with go held: acts as a fresh press after release
    press(0, GU, 1);
    press(1, PU, 2);
    go_btn = 1;
    rst = 1;
    tick;
    exp_cycles = 0;
    chk_cleared;
    rst = 0;
    expect_cmd(GU, 1, 3);
    repeat (4) tick;
    go_btn = 0;
    repeat (3) tick;
    chk("post_rst_state", state, 1);
    chk("post_rst_busy", busy, 1);
    done(0, GD, 3, 0);
    done(1, NONE, 0, 1);
    repeat (4) tick;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
